// File: rtl/branch_resolve_unit.sv
// Branch resolution: in-order prediction FIFO from IF to EX, predictor update, flush/redirect.
// Optional perf counters (perf_br_o, perf_miss_o) enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_push_i,
    input  logic [31:0]      if_pc_i,
    input  logic             if_pr_i,
    input  logic [31:0]      if_pr_addr_i,
    input  logic             ex_valid_i,
    input  logic [31:0]      ex_pc_i,
    input  logic             ex_is_br_i,
    input  logic             ex_taken_i,
    input  logic [31:0]      ex_target_i,
    output logic             full_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             upd_v_o,
    output logic [IDX_W-1:0] upd_idx_o,
    output logic             upd_hit_o,
    output logic             upd_inv_o,
    output logic [31:0]      upd_target_o,
    output logic             err_o
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_br_o,
    output logic [31:0]      perf_miss_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [DEPTH-1:0] pr_q, pr_d;
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             flush_q, flush_d;
    logic [31:0]      rpc_q, rpc_d;
    logic             upd_v_q, upd_v_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_hit_q, upd_hit_d;
    logic             upd_inv_q, upd_inv_d;
    logic [31:0]      upd_tgt_q, upd_tgt_d;

    logic [31:0] head_pc, head_addr;
    logic        head_pr, full, pop, push_ok, correct, mispred;

    always_comb begin
        head_pc   = pc_q[rd_q];
        head_addr = addr_q[rd_q];
        head_pr   = pr_q[rd_q];
        full      = (cnt_q == CW'(DEPTH));
        pop       = ex_valid_i && (cnt_q != '0);
        correct   = (!ex_is_br_i && !head_pr)
                  | (ex_is_br_i && !ex_taken_i && !head_pr)
                  | (ex_is_br_i && ex_taken_i && head_pr
                     && (ex_target_i == head_addr));
        mispred   = pop && !correct;
        // the flush cycle's fetch is a killed younger instruction too
        push_ok   = if_push_i && !flush_q && !mispred && (!full || pop);

        pc_d   = pc_q;
        addr_d = addr_q;
        pr_d   = pr_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        err_d  = err_q
               | (ex_valid_i && (cnt_q == '0))
               | (pop && (ex_pc_i != head_pc))
               | (if_push_i && full && !pop && !flush_q);

        if (mispred) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop) rd_d = rd_q + 1'b1;
            if (push_ok) begin
                pc_d[wr_q]   = if_pc_i;
                addr_d[wr_q] = if_pr_addr_i;
                pr_d[wr_q]   = if_pr_i;
                wr_d         = wr_q + 1'b1;
            end
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
        end

        flush_d   = mispred;
        rpc_d     = '0;
        if (mispred)
            rpc_d = (ex_is_br_i && ex_taken_i) ? ex_target_i : head_pc + 32'd4;
        upd_v_d   = pop && (ex_is_br_i || head_pr);
        upd_idx_d = upd_v_d ? head_pc[IDX_W-1:0] : '0;
        upd_hit_d = upd_v_d && correct;
        upd_inv_d = pop && !ex_is_br_i && head_pr;
        upd_tgt_d = upd_v_d ? ex_target_i : '0;
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        addr_q <= addr_d;
        pr_q   <= pr_d;
        if (rst) begin
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            flush_q   <= 1'b0;
            rpc_q     <= '0;
            upd_v_q   <= 1'b0;
            upd_idx_q <= '0;
            upd_hit_q <= 1'b0;
            upd_inv_q <= 1'b0;
            upd_tgt_q <= '0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            flush_q   <= flush_d;
            rpc_q     <= rpc_d;
            upd_v_q   <= upd_v_d;
            upd_idx_q <= upd_idx_d;
            upd_hit_q <= upd_hit_d;
            upd_inv_q <= upd_inv_d;
            upd_tgt_q <= upd_tgt_d;
        end
    end

    assign full_o        = full;
    assign flush_o       = flush_q;
    assign redirect_o    = flush_q;
    assign redirect_pc_o = rpc_q;
    assign upd_v_o       = upd_v_q;
    assign upd_idx_o     = upd_idx_q;
    assign upd_hit_o     = upd_hit_q;
    assign upd_inv_o     = upd_inv_q;
    assign upd_target_o  = upd_tgt_q;
    assign err_o         = err_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_br_d, perf_miss_q, perf_miss_d;

    always_comb begin
        perf_br_d   = perf_br_q;
        perf_miss_d = perf_miss_q;
        if (pop && ex_is_br_i && (perf_br_q != '1))
            perf_br_d = perf_br_q + 32'd1;
        if (mispred && (perf_miss_q != '1))
            perf_miss_d = perf_miss_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q   <= '0;
            perf_miss_q <= '0;
        end else begin
            perf_br_q   <= perf_br_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_br_o   = perf_br_q;
    assign perf_miss_o = perf_miss_q;
`endif
endmodule
